seg_scan_ctrl: RTL and testbench

Sequencing controller for a multiplexed eight-segment LED display. It accepts a signed binary value over a valid/ready handshake. It converts the value to BCD serially with a shift-add-3 state machine and commits the result atomically to a display register. It then time-multiplexes the digits onto shared segment lines using the team's standard BCD-to-eight-segment encoding (active-low segments, Minus/Empty codes). It sits between the measurement/datapath logic and the board's digit anodes and segment pins.

---
 rtl/seg_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Signed value -> serial shift-add-3 BCD -> multiplexed active-low 8-segment display scanner.
// Build option: define SEG_LEADING_BLANK_EN to blank leading zero magnitude digits.
module seg_scan_ctrl #(
   parameter int Digits      = 4,
   parameter int Width       = 16,
   parameter int ClkPerDigit = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [Width-1:0] value,
   input  logic                    valid,
   output logic                    ready,
   output logic                    ovf,
   output logic [7:0]              seg,
   output logic [Digits-1:0]       an
);

   function automatic int dec_digits(input int w);
      longint v;
      int     n;
      v = longint'(1) << w;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (v > 0) begin
            v = v / 10;
            n++;
         end
      end
      return n;
   endfunction

   localparam int NibNeed = dec_digits(Width);
   localparam int AccNib  = (NibNeed > Digits) ? NibNeed : Digits;
   localparam int AccW    = AccNib * 4;
   localparam int CntW    = $clog2(Width + 1);
   localparam int IdxW    = (Digits > 1) ? $clog2(Digits) : 1;
   localparam int RefW    = (ClkPerDigit > 1) ? $clog2(ClkPerDigit) : 1;
   localparam logic [3:0] CodeMinus = 4'b1010;
   localparam logic [3:0] CodeEmpty = 4'b1111;

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t            state_q, state_n;
   logic [CntW-1:0]   bit_cnt_q;
   logic [Width-1:0]  mag_q;
   logic              neg_q;
   logic [AccW-1:0]   acc_q;
   logic [3:0]        disp_q [Digits];
   logic [3:0]        disp_n [Digits];
   logic              ovf_n;
   logic              accept;
   logic [Width-1:0]  value_u;
   logic [RefW-1:0]   ref_q;
   logic [IdxW-1:0]   idx_q;

   function automatic logic [AccW-1:0] dd_step(input logic [AccW-1:0] acc, input logic b);
      logic [AccW-1:0] adj;
      for (int i = 0; i < AccNib; i++) begin
         adj[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
      end
      return {adj[AccW-2:0], b};
   endfunction

   function automatic logic [7:0] seg_enc(input logic [3:0] code);
      case (code)
         4'd0:      return 8'hC0;
         4'd1:      return 8'hF9;
         4'd2:      return 8'hA4;
         4'd3:      return 8'hB0;
         4'd4:      return 8'h99;
         4'd5:      return 8'h92;
         4'd6:      return 8'h82;
         4'd7:      return 8'hF8;
         4'd8:      return 8'h80;
         4'd9:      return 8'h90;
         CodeMinus: return 8'hBF;
         default:   return 8'hFF;
      endcase
   endfunction

   assign ready   = (state_q == IDLE);
   assign accept  = valid && (state_q == IDLE);
   assign value_u = value;

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (valid) state_n = CONV;
         CONV:    if (bit_cnt_q == CntW'(Width - 1)) state_n = COMMIT;
         COMMIT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
      end else begin
         state_q <= state_n;
         if (accept)                bit_cnt_q <= '0;
         else if (state_q == CONV)  bit_cnt_q <= bit_cnt_q + CntW'(1);
      end
   end

   // Conversion datapath: magnitude is Width-bit unsigned so the most negative input is exact
   always_ff @(posedge clk) begin
      if (accept) begin
         mag_q <= value_u[Width-1] ? (~value_u + Width'(1)) : value_u;
         neg_q <= value_u[Width-1];
         acc_q <= '0;
      end else if (state_q == CONV) begin
         acc_q <= dd_step(acc_q, mag_q[Width-1]);
         mag_q <= {mag_q[Width-2:0], 1'b0};
      end
   end

   always_comb begin
`ifdef SEG_LEADING_BLANK_EN
      logic seen;
      seen = 1'b0;
`endif
      ovf_n = |acc_q[AccW-1:(Digits-1)*4];
      for (int i = 0; i < Digits; i++) disp_n[i] = CodeEmpty;
      if (ovf_n) begin
         for (int i = 0; i < Digits; i++) disp_n[i] = CodeMinus;
      end else begin
         for (int i = Digits - 2; i >= 0; i--) begin
`ifdef SEG_LEADING_BLANK_EN
            if (acc_q[i*4 +: 4] != 4'd0) seen = 1'b1;
            disp_n[i] = (seen || i == 0) ? acc_q[i*4 +: 4] : CodeEmpty;
`else
            disp_n[i] = acc_q[i*4 +: 4];
`endif
         end
         disp_n[Digits-1] = (neg_q && (|acc_q)) ? CodeMinus : CodeEmpty;
      end
   end

   // Display register: whole-word update on the commit edge only
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
         for (int i = 0; i < Digits; i++) disp_q[i] <= CodeEmpty;
      end else if (state_q == COMMIT) begin
         ovf <= ovf_n;
         for (int i = 0; i < Digits; i++) disp_q[i] <= disp_n[i];
      end
   end

   // Scanner runs free of the FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_q <= '0;
         idx_q <= '0;
         an    <= ~Digits'(1);
         seg   <= 8'hFF;
      end else begin
         if (ref_q == RefW'(ClkPerDigit - 1)) begin
            ref_q <= '0;
            idx_q <= (idx_q == IdxW'(Digits - 1)) ? '0 : idx_q + IdxW'(1);
         end else begin
            ref_q <= ref_q + RefW'(1);
         end
         an  <= ~(Digits'(1) << idx_q);
         seg <= seg_enc(disp_q[idx_q]);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a decimal-arithmetic display model.
module tb_seg_scan_ctrl;
   localparam int Digits = 4, Width = 16, ClkPerDigit = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [15:0] value = '0;
   logic               valid = 1'b0;
   logic               ready, ovf;
   logic [7:0]         seg;
   logic [3:0]         an;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] exp_seg [4];
   logic       exp_ovf;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.Digits(Digits), .Width(Width), .ClkPerDigit(ClkPerDigit)) dut (
      .clk(clk), .rst(rst), .value(value), .valid(valid),
      .ready(ready), .ovf(ovf), .seg(seg), .an(an)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] digit_pat(input int d);
      case (d)
         0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0; 4: return 8'h99;
         5: return 8'h92; 6: return 8'h82; 7: return 8'hF8; 8: return 8'h80; default: return 8'h90;
      endcase
   endfunction

   // Expected display from plain decimal arithmetic on the signed value
   task automatic model(input int v);
      int mag, p;
      mag = (v < 0) ? -v : v;
      exp_ovf = (mag > 999);
      if (exp_ovf) begin
         for (int i = 0; i < 4; i++) exp_seg[i] = 8'hBF;
      end else begin
         p = 1;
         for (int i = 0; i < 3; i++) begin
            exp_seg[i] = digit_pat((mag / p) % 10);
`ifdef SEG_LEADING_BLANK_EN
            if (i > 0 && mag < p) exp_seg[i] = 8'hFF;
`endif
            p = p * 10;
         end
         exp_seg[3] = (v < 0 && mag != 0) ? 8'hBF : 8'hFF;
      end
   endtask

   task automatic send(input int v);
      int w;
      @(negedge clk);
      value = v[15:0];
      valid = 1'b1;
      w = 0;
      while (!ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_accept", ready, 1);
      @(posedge clk);
      #1;
      valid = 1'b0;
      check("ready_low_T0", ready, 0);
   endtask

   task automatic wait_commit();
      int busy;
      busy = 1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready) break;
         busy++;
      end
      check("busy_cycles", busy, 17);
      check("ovf_at_commit", ovf, exp_ovf);
   endtask

   task automatic read_display();
      logic [7:0] seen [4];
      for (int d = 0; d < 4; d++) seen[d] = 8'h00;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         check("an_onehot", $countones(~an), 1);
         for (int d = 0; d < 4; d++) if (an[d] == 1'b0) seen[d] = seg;
      end
      for (int d = 0; d < 4; d++) check($sformatf("digit%0d", d), seen[d], exp_seg[d]);
   endtask

   task automatic run_value(input int v);
      model(v);
      send(v);
      wait_commit();
      read_display();
   endtask

   task automatic busy_hold_test();
      logic [7:0] d0;
      int first_rdy, acc_k, second;
      d0 = 8'h00;
      first_rdy = -1;
      acc_k = -1;
      second = -1;
      @(negedge clk);
      value = 16'sd7;
      valid = 1'b1;
      check("t5_ready_idle", ready, 1);
      @(posedge clk);
      #1;
      value = 16'sd9;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (first_rdy < 0 && ready) first_rdy = k;
         else if (first_rdy >= 0 && acc_k < 0 && !ready) begin
            acc_k = k;
            valid = 1'b0;
         end else if (acc_k >= 0 && ready) begin
            second = k;
            break;
         end
         if (k >= 19 && k <= 34 && an == 4'b1110) d0 = seg;
      end
      valid = 1'b0;
      check("t5_first_commit", first_rdy, 17);
      check("t5_second_accept", acc_k, 18);
      check("t5_second_commit", second, 35);
      check("t5_digit0_seven", d0, 8'hF8);
      model(9);
      check("t5_ovf", ovf, exp_ovf);
      read_display();
   endtask

   initial begin
      logic [3:0]         exp_an;
      logic signed [15:0] r16;
      int                 v;
      int                 edges [8];
      edges = '{999, -999, 1000, -1, 1, -32768, 32767, -1000};

      repeat (3) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_ovf", ovf, 0);
      check("rst_seg", seg, 8'hFF);
      check("rst_an", an, 4'b1110);
      rst = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk);
         #1;
         exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
         check("idle_an", an, exp_an);
         check("idle_seg", seg, 8'hFF);
         check("idle_ready", ready, 1);
         check("idle_ovf", ovf, 0);
      end

      run_value(123);
      run_value(-45);
      run_value(1000);
      run_value(-32768);
      run_value(0);
      busy_hold_test();

      for (int n = 0; n < 12; n++) begin
         case ($urandom_range(0, 2))
            0: begin
               v = $urandom_range(0, 999);
               if ($urandom_range(0, 1) == 1) v = -v;
            end
            1: begin
               r16 = $urandom;
               v = r16;
            end
            default: v = edges[$urandom_range(0, 7)];
         endcase
         run_value(v);
      end

      run_value(-32768);
      send(555);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_seg", seg, 8'hFF);
      check("midrst_ready", ready, 1);
      check("midrst_ovf", ovf, 0);
      check("midrst_an", an, 4'b1110);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) exp_seg[i] = 8'hFF;
      read_display();
      check("after_rst_ready", ready, 1);
      check("after_rst_ovf", ovf, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
